// File: rtl/video_timing_pkg.sv
// Purpose: shared 720p timing constants, count widths and the sync-bundle type
//          for the video timing generator.
package video_timing_pkg;

    // Default 1280x720 timing, pixel and line units
    localparam int unsigned ACTIVE_H_720P  = 1280;
    localparam int unsigned H_FP_720P      = 110;
    localparam int unsigned H_SYNC_720P    = 40;
    localparam int unsigned H_BP_720P      = 220;
    localparam int unsigned ACTIVE_V_720P  = 720;
    localparam int unsigned V_FP_720P      = 5;
    localparam int unsigned V_SYNC_720P    = 5;
    localparam int unsigned V_BP_720P      = 20;
    localparam int unsigned FPS_DEF        = 60;
    localparam int unsigned PIPE_DELAY_DEF = 4;

    localparam int unsigned TOTAL_H_720P = ACTIVE_H_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
    localparam int unsigned TOTAL_V_720P = ACTIVE_V_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    // Sized for totals up to 2048 x 1024 and a 6-bit frame counter
    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;
    localparam int unsigned FC_W     = 6;

    // Bundle carried through the downstream delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic ad;
    } sync_t;

    // Half-open window test, done at 32 bits so window edges past the count width cannot wrap
    function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                       input int unsigned hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/video_timing_gen_pipeline.sv
// Purpose: fixed-latency delay line; STAGES=0 degenerates to a wire.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears every stage
//   din  - WIDTH-bit input
//   dout - din delayed STAGES cycles
module pipeline #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_regs
            // Index 0 is the newest sample, STAGES-1 the oldest
            logic [STAGES-1:0][WIDTH-1:0] stage_q;

            // Shift by appending din and truncating the oldest entry off the top
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= (STAGES*WIDTH)'({stage_q, din});
                end
            end

            assign dout = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Purpose: raster timing generator: pixel/line counters, registered sync,
//          active-draw and new-frame decodes, frame counter, and copies of the
//          sync/active flags delayed to match a downstream pixel pipeline.
// Ports:
//   clk_in     - pixel clock
//   rst_in     - asynchronous active-high reset
//   hcount_out - horizontal pixel index
//   vcount_out - line index
//   hs_out     - hsync, aligned with the counts
//   vs_out     - vsync, aligned with the counts
//   ad_out     - active-draw, aligned with the counts
//   nf_out     - one-cycle pulse at (ACTIVE_H, ACTIVE_V), once per frame
//   fc_out     - frame count modulo FPS
//   hs_d_out   - hs_out delayed PIPE_DELAY cycles
//   vs_d_out   - vs_out delayed PIPE_DELAY cycles
//   ad_d_out   - ad_out delayed PIPE_DELAY cycles
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_H   = ACTIVE_H_720P,
    parameter int unsigned H_FP       = H_FP_720P,
    parameter int unsigned H_SYNC     = H_SYNC_720P,
    parameter int unsigned H_BP       = H_BP_720P,
    parameter int unsigned ACTIVE_V   = ACTIVE_V_720P,
    parameter int unsigned V_FP       = V_FP_720P,
    parameter int unsigned V_SYNC     = V_SYNC_720P,
    parameter int unsigned V_BP       = V_BP_720P,
    parameter int unsigned FPS        = FPS_DEF,
    parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out,
    output logic                hs_d_out,
    output logic                vs_d_out,
    output logic                ad_d_out
);

    localparam int unsigned TOTAL_H  = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int unsigned TOTAL_V  = ACTIVE_V + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = ACTIVE_H + H_FP;
    localparam int unsigned HS_STOP  = HS_START + H_SYNC;
    localparam int unsigned VS_START = ACTIVE_V + V_FP;
    localparam int unsigned VS_STOP  = VS_START + V_SYNC;

    logic                h_wrap_c;
    logic                v_wrap_c;
    logic [HCOUNT_W-1:0] h_next_c;
    logic [VCOUNT_W-1:0] v_next_c;
    logic                hs_c;
    logic                vs_c;
    logic                ad_c;
    logic                nf_c;
    sync_t               sync_now;
    sync_t               sync_dly;

    // Next counter values; flags decode these so they land on the same edge as the counts
    always_comb begin
        h_wrap_c = (hcount_out == HCOUNT_W'(TOTAL_H - 1));
        v_wrap_c = (vcount_out == VCOUNT_W'(TOTAL_V - 1));
        h_next_c = h_wrap_c ? '0 : hcount_out + HCOUNT_W'(1);
        v_next_c = vcount_out;
        if (h_wrap_c) begin
            v_next_c = v_wrap_c ? '0 : vcount_out + VCOUNT_W'(1);
        end
        hs_c = in_window(32'(h_next_c), HS_START, HS_STOP);
        vs_c = in_window(32'(v_next_c), VS_START, VS_STOP);
        ad_c = (32'(h_next_c) < ACTIVE_H) && (32'(v_next_c) < ACTIVE_V);
        nf_c = (32'(h_next_c) == ACTIVE_H) && (32'(v_next_c) == ACTIVE_V);
    end

    // Reset parks the counters on the last pixel so the first edge lands on (0,0)
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_out <= HCOUNT_W'(TOTAL_H - 1);
            vcount_out <= VCOUNT_W'(TOTAL_V - 1);
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else begin
            hcount_out <= h_next_c;
            vcount_out <= v_next_c;
            hs_out     <= hs_c;
            vs_out     <= vs_c;
            ad_out     <= ad_c;
            nf_out     <= nf_c;
            if (nf_c) begin
                fc_out <= (fc_out == FC_W'(FPS - 1)) ? '0 : fc_out + FC_W'(1);
            end
        end
    end

    // Delayed flags track the renderer's colour output latency
    assign sync_now = '{hs: hs_out, vs: vs_out, ad: ad_out};

    pipeline #(
        .WIDTH  ($bits(sync_t)),
        .STAGES (PIPE_DELAY)
    ) u_pipe (
        .clk  (clk_in),
        .rst  (rst_in),
        .din  (sync_now),
        .dout (sync_dly)
    );

    assign hs_d_out = sync_dly.hs;
    assign vs_d_out = sync_dly.vs;
    assign ad_d_out = sync_dly.ad;

endmodule

// File: tb/tb_video_timing_gen.sv
// Purpose: directed self-checking bench for video_timing_gen: default 720p
//          instance, reduced-timing instance, and a reduced zero-delay instance.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_s;

    // Default 720p instance
    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic        d_hs, d_vs, d_ad, d_nf, d_hs_d, d_vs_d, d_ad_d;
    logic [5:0]  d_fc;

    // Reduced timing: TOTAL_H=11, TOTAL_V=7, PIPE_DELAY=4
    logic [10:0] s_h;
    logic [9:0]  s_v;
    logic        s_hs, s_vs, s_ad, s_nf, s_hs_d, s_vs_d, s_ad_d;
    logic [5:0]  s_fc;

    // Reduced timing, PIPE_DELAY=0
    logic [10:0] z_h;
    logic [9:0]  z_v;
    logic        z_hs, z_vs, z_ad, z_nf, z_hs_d, z_vs_d, z_ad_d;
    logic [5:0]  z_fc;

    video_timing_gen dut (
        .clk_in(clk), .rst_in(rst),
        .hcount_out(d_h), .vcount_out(d_v),
        .hs_out(d_hs), .vs_out(d_vs), .ad_out(d_ad), .nf_out(d_nf), .fc_out(d_fc),
        .hs_d_out(d_hs_d), .vs_d_out(d_vs_d), .ad_d_out(d_ad_d)
    );

    video_timing_gen #(
        .ACTIVE_H(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .ACTIVE_V(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FPS(3), .PIPE_DELAY(4)
    ) dut_s (
        .clk_in(clk), .rst_in(rst_s),
        .hcount_out(s_h), .vcount_out(s_v),
        .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc),
        .hs_d_out(s_hs_d), .vs_d_out(s_vs_d), .ad_d_out(s_ad_d)
    );

    video_timing_gen #(
        .ACTIVE_H(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .ACTIVE_V(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FPS(3), .PIPE_DELAY(0)
    ) dut_z (
        .clk_in(clk), .rst_in(rst_s),
        .hcount_out(z_h), .vcount_out(z_v),
        .hs_out(z_hs), .vs_out(z_vs), .ad_out(z_ad), .nf_out(z_nf), .fc_out(z_fc),
        .hs_d_out(z_hs_d), .vs_d_out(z_vs_d), .ad_d_out(z_ad_d)
    );

    int checks = 0;
    int errors = 0;

    // Last five samples of each flag; bit 4 is the sample four edges ago
    logic [4:0] hd_hs, hd_vs, hd_ad;
    logic [4:0] hs_hs, hs_vs, hs_ad;
    int d_mis = 0;
    int s_mis = 0;
    int z_mis = 0;

    typedef struct {
        int adv;
        int h;
        int v;
        int hs;
        int ad;
    } vec_t;

    vec_t tbl[9];
    int   fc_seen[8];
    int   fc_want[7] = '{1, 2, 0, 1, 2, 0, 1};

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_d();
        hd_hs = '0; hd_vs = '0; hd_ad = '0;
    endtask

    task automatic clear_s();
        hs_hs = '0; hs_vs = '0; hs_ad = '0;
    endtask

    // Advance n edges, sampling 1 time unit after each, and audit the delay lines
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            hd_hs = {hd_hs[3:0], d_hs};
            hd_vs = {hd_vs[3:0], d_vs};
            hd_ad = {hd_ad[3:0], d_ad};
            hs_hs = {hs_hs[3:0], s_hs};
            hs_vs = {hs_vs[3:0], s_vs};
            hs_ad = {hs_ad[3:0], s_ad};
            if ({d_hs_d, d_vs_d, d_ad_d} != {hd_hs[4], hd_vs[4], hd_ad[4]}) d_mis++;
            if ({s_hs_d, s_vs_d, s_ad_d} != {hs_hs[4], hs_vs[4], hs_ad[4]}) s_mis++;
            if ({z_hs_d, z_vs_d, z_ad_d} != {z_hs, z_vs, z_ad}) z_mis++;
        end
    endtask

    initial begin
        int hs_cycles;
        int hs_first;
        int vs_cycles;
        int nf_cnt;
        int model_mis;
        int early_bad;
        logic prev_hs;

        // Edge offsets and expected (h, v, hs, ad) along the first line and into the second
        tbl[0] = '{1,    0,    0, 0, 1};
        tbl[1] = '{1279, 1279, 0, 0, 1};
        tbl[2] = '{1,    1280, 0, 0, 0};
        tbl[3] = '{109,  1389, 0, 0, 0};
        tbl[4] = '{1,    1390, 0, 1, 0};
        tbl[5] = '{39,   1429, 0, 1, 0};
        tbl[6] = '{1,    1430, 0, 0, 0};
        tbl[7] = '{219,  1649, 0, 0, 0};
        tbl[8] = '{1,    0,    1, 0, 1};

        rst   = 1'b1;
        rst_s = 1'b1;
        clear_d();
        clear_s();
        step(3);

        chk("rst_h", int'(d_h), 1649);
        chk("rst_v", int'(d_v), 749);
        chk("rst_flags", int'({d_hs, d_vs, d_ad, d_nf}), 0);
        chk("rst_fc", int'(d_fc), 0);
        chk("rst_dly", int'({d_hs_d, d_vs_d, d_ad_d}), 0);

        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].adv);
            chk($sformatf("tbl%0d_h", i), int'(d_h), tbl[i].h);
            chk($sformatf("tbl%0d_v", i), int'(d_v), tbl[i].v);
            chk($sformatf("tbl%0d_hs", i), int'(d_hs), tbl[i].hs);
            chk($sformatf("tbl%0d_ad", i), int'(d_ad), tbl[i].ad);
            chk($sformatf("tbl%0d_vs_nf_fc", i), int'({d_vs, d_nf, d_fc}), 0);
        end

        // One full line: hsync width and start position
        hs_cycles = 0;
        hs_first  = -1;
        prev_hs   = d_hs;
        for (int k = 0; k < 1650; k++) begin
            step(1);
            if (d_hs) hs_cycles++;
            if (d_hs && !prev_hs && hs_first < 0) hs_first = int'(d_h);
            prev_hs = d_hs;
        end
        chk("line_hs_cycles", hs_cycles, 40);
        chk("line_hs_start", hs_first, 1390);
        chk("line_end_h", int'(d_h), 0);
        chk("line_end_v", int'(d_v), 2);

        // Asynchronous reset mid-frame
        step(500);
        chk("pre_rst_h", int'(d_h), 500);
        chk("pre_rst_ad", int'(d_ad), 1);
        rst = 1'b1;
        clear_d();
        #1;
        chk("async_rst_h", int'(d_h), 1649);
        chk("async_rst_v", int'(d_v), 749);
        chk("async_rst_flags", int'({d_hs, d_vs, d_ad, d_nf, d_hs_d, d_vs_d, d_ad_d}), 0);
        chk("async_rst_fc", int'(d_fc), 0);
        step(1);
        chk("held_rst_h", int'(d_h), 1649);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("rel_h", int'(d_h), 0);
        chk("rel_v", int'(d_v), 0);
        chk("rel_ad", int'(d_ad), 1);
        chk("rel_fc", int'(d_fc), 0);

        // Reduced timing: seven frames against an index-derived raster model
        @(negedge clk);
        rst_s     = 1'b0;
        nf_cnt    = 0;
        vs_cycles = 0;
        model_mis = 0;
        for (int k = 0; k < 539; k++) begin
            int eh, ev;
            logic ehs, evs, ead, enf;
            step(1);
            eh  = k % 11;
            ev  = (k / 11) % 7;
            ehs = (eh == 9);
            evs = (ev == 5);
            ead = (eh < 8) && (ev < 4);
            enf = (eh == 8) && (ev == 4);
            if (int'(s_h) != eh || int'(s_v) != ev ||
                {s_hs, s_vs, s_ad, s_nf} != {ehs, evs, ead, enf}) model_mis++;
            if (int'(z_h) != eh || int'(z_v) != ev ||
                {z_hs, z_vs, z_ad, z_nf} != {ehs, evs, ead, enf}) model_mis++;
            if (k < 77 && s_vs) vs_cycles++;
            if (s_nf) begin
                if (nf_cnt < 8) fc_seen[nf_cnt] = int'(s_fc);
                nf_cnt++;
            end
        end
        chk("small_model", model_mis, 0);
        chk("small_nf_count", nf_cnt, 7);
        chk("small_vs_cycles", vs_cycles, 11);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("small_fc%0d", i), fc_seen[i], fc_want[i]);
        end

        // Reduced timing: reset with fc nonzero, fc must stay 0 until the next new-frame
        chk("small_pre_rst_fc", int'(s_fc), 1);
        rst_s = 1'b1;
        clear_s();
        #1;
        chk("small_rst_h", int'(s_h), 10);
        chk("small_rst_v", int'(s_v), 6);
        chk("small_rst_fc", int'(s_fc), 0);
        chk("small_rst_dly", int'({s_hs_d, s_vs_d, s_ad_d}), 0);
        step(2);
        @(negedge clk);
        rst_s     = 1'b0;
        early_bad = 0;
        for (int k = 0; k < 52; k++) begin
            step(1);
            if (s_fc != 6'd0 || s_nf) early_bad++;
        end
        chk("small_fc_held", early_bad, 0);
        step(1);
        chk("small_nf_after", int'(s_nf), 1);
        chk("small_fc_after", int'(s_fc), 1);

        chk("dly_default", d_mis, 0);
        chk("dly_small", s_mis, 0);
        chk("dly_zero", z_mis, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
